// File: rtl/tb_fifo_pkg.sv
// Shared FIFO types and sizes.
//   DATA_WIDTH : bits per stored word
//   DEPTH      : number of storage entries (power of two)
//   ADDR_WIDTH : storage index width
//   data_t     : one FIFO word
//   ptr_t      : read/write pointer; the extra MSB is the wrap flag
package tb_fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH:0]   ptr_t;
endpackage

// File: rtl/tb_fifo_if.sv
// FIFO bundle.
//   clk      : interface port, rising-edge clock
//   rst      : async reset, active-low
//   push/pop : write/read requests
//   data_in  : word written on accepted push
//   data_out : registered word from last accepted pop
//   full     : DEPTH words stored
//   empty    : no words stored
interface tb_fifo_if
    import tb_fifo_pkg::*;
(
    input logic clk
);
    logic  rst;
    logic  push;
    logic  pop;
    data_t data_in;
    data_t data_out;
    logic  full;
    logic  empty;

    modport fifo_top (
        input  clk,
        input  rst,
        input  push,
        input  pop,
        input  data_in,
        output data_out,
        output full,
        output empty
    );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage, one synchronous write and one synchronous read port.
//   clk     : clock
//   rst_n   : async active-low reset, clears the read register only
//   wr_en   : write strobe; wr_addr/wr_data
//   rd_en   : read strobe; rd_addr
//   rd_data : registered read word, held when rd_en is low
// A read and write to the same address on one edge return the old word,
// which the wrapper relies on for push+pop while full.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    // Storage is intentionally not reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_wrapper.sv
// Synchronous FIFO: pointer/flag control around fifo_ram.
//   itf (tb_fifo_if.fifo_top): clk, rst (async active-low), push, pop,
//   data_in -> data_out (1-cycle registered), full, empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// with all DEPTH entries in use.
module fifo_wrapper
    import tb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = tb_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = tb_fifo_pkg::DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    tb_fifo_if.fifo_top itf
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;
    logic                full_w;
    logic                empty_w;

    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // When full, a concurrent pop frees the slot being written this edge.
    assign push_ok = itf.push && (!full_w || itf.pop);
    assign pop_ok  = itf.pop && !empty_w;

    always_ff @(posedge itf.clk or negedge itf.rst) begin
        if (!itf.rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (itf.clk),
        .rst_n   (itf.rst),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (itf.data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (itf.data_out)
    );

    assign itf.full  = full_w;
    assign itf.empty = empty_w;
endmodule

// File: tb/tb_fifo_wrapper.sv
// Directed bench for fifo_wrapper.
module tb_fifo_wrapper;
    import tb_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    tb_fifo_if u_if (.clk(clk));
    fifo_wrapper dut (.itf(u_if));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, sample 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d);
        u_if.push    = p;
        u_if.pop     = q;
        u_if.data_in = data_t'(d);
        @(posedge clk);
        #1;
        u_if.push = 1'b0;
        u_if.pop  = 1'b0;
    endtask

    task automatic do_reset();
        u_if.rst = 1'b0;
        #3;
        u_if.rst = 1'b1;
    endtask

    initial begin
        u_if.rst     = 1'b1;
        u_if.push    = 1'b0;
        u_if.pop     = 1'b0;
        u_if.data_in = '0;
        #2;
        u_if.rst = 1'b0;
        #1;
        chk("rst_empty", 32'(u_if.empty), 32'd1);
        chk("rst_full",  32'(u_if.full),  32'd0);
        chk("rst_dout",  32'(u_if.data_out), 32'd0);
        @(posedge clk);
        #1;
        u_if.rst = 1'b1;

        // Basic: 11 in, 11 out
        for (int i = 0; i <= 10; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk("basic_full", 32'(u_if.full), 32'd0);
        end
        for (int i = 0; i <= 10; i++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("basic_pop", 32'(u_if.data_out), 32'(i));
        end
        chk("basic_empty", 32'(u_if.empty), 32'd1);

        // Overflow: 21 pushes, only 16 stored
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 14) chk("ovf_notfull", 32'(u_if.full), 32'd0);
            if (i >= 15) chk("ovf_full", 32'(u_if.full), 32'd1);
        end
        chk("ovf_wr_ptr", 32'(dut.wr_ptr), 32'd16);
        for (int i = 0; i <= 20; i++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("ovf_pop", 32'(u_if.data_out), (i < 16) ? 32'(i) : 32'd15);
        end
        chk("ovf_empty", 32'(u_if.empty), 32'd1);

        // Underflow: 16 in, 21 pops
        do_reset();
        for (int i = 0; i <= 15; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i <= 20; i++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("udf_pop", 32'(u_if.data_out), (i < 16) ? 32'(i) : 32'd15);
            if (i >= 16) chk("udf_empty", 32'(u_if.empty), 32'd1);
        end
        chk("udf_rd_ptr", 32'(dut.rd_ptr), 32'd16);
        chk("udf_wr_ptr", 32'(dut.wr_ptr), 32'd16);

        // Wrap: 10 in, 8 out, 14 in -> full, 16 out
        do_reset();
        for (int i = 0; i <= 9; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i <= 7; i++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("wrap_pop_a", 32'(u_if.data_out), 32'(i));
        end
        for (int i = 10; i <= 23; i++) step(1'b1, 1'b0, 8'(i));
        chk("wrap_full", 32'(u_if.full), 32'd1);
        for (int i = 8; i <= 23; i++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("wrap_pop_b", 32'(u_if.data_out), 32'(i));
        end
        chk("wrap_empty", 32'(u_if.empty), 32'd1);

        // Full simultaneous push+pop
        do_reset();
        for (int i = 0; i <= 15; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 8'd99);
        chk("fsim_dout", 32'(u_if.data_out), 32'd0);
        chk("fsim_full", 32'(u_if.full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'd0);
            chk("fsim_pop", 32'(u_if.data_out), (i <= 15) ? 32'(i) : 32'd99);
        end
        chk("fsim_empty", 32'(u_if.empty), 32'd1);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
        step(1'b0, 1'b1, 8'd0);
        chk("mid_pre_dout", 32'(u_if.data_out), 32'h11);
        #3;
        u_if.rst = 1'b0;
        #1;
        chk("mid_empty", 32'(u_if.empty), 32'd1);
        chk("mid_full",  32'(u_if.full),  32'd0);
        chk("mid_dout",  32'(u_if.data_out), 32'd0);
        u_if.rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 8'd0);
        chk("mid_pop_dout",  32'(u_if.data_out), 32'd0);
        chk("mid_pop_empty", 32'(u_if.empty), 32'd1);

        // Push+pop while empty: only the push lands
        step(1'b1, 1'b1, 8'h42);
        chk("epp_dout",  32'(u_if.data_out), 32'd0);
        chk("epp_empty", 32'(u_if.empty), 32'd0);
        step(1'b0, 1'b1, 8'd0);
        chk("epp_pop",   32'(u_if.data_out), 32'h42);
        chk("epp_empty2", 32'(u_if.empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
